// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of RX/TX handshake and ALU operand/result signals around the command sequencer.
// master is the sequencer side; slave is the UART/ALU side.
interface alu_cmd_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  rx_data, rx_done, tx_done, alu_result,
    output alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err, overrun
  );

  modport slave (
    output rx_data, rx_done, tx_done, alu_result,
    input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err, overrun
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Collects A/operator/B frames from the UART RX stream, drives the ALU and sends one TX byte per frame.
// Optional inter-byte timeout in GET_OP/GET_B is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer #(
  parameter int         ALU_LAT     = 1,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] ERR_BYTE    = 8'h3F
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_cmd_sequencer_if.master  bus
);

  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {IDLE, GET_OP, GET_B, EXEC, SEND, WAIT_TX} state_t;

  state_t          state_q, state_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [5:0]      alu_op_q, alu_op_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [6:0]      op_dec;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Bit 6 flags a recognised operator; bits 5:0 carry the ALU opcode.
  function automatic logic [6:0] decode_op(input logic [7:0] c);
    case (c)
      8'h2B:   return {1'b1, 6'b100000};
      8'h2D:   return {1'b1, 6'b100010};
      8'h26:   return {1'b1, 6'b100100};
      8'h7C:   return {1'b1, 6'b100101};
      8'h5E:   return {1'b1, 6'b100110};
      8'h7E:   return {1'b1, 6'b100111};
      8'h3E:   return {1'b1, 6'b000011};
      8'h3C:   return {1'b1, 6'b000010};
      default: return 7'b0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    tx_data_d   = tx_data_q;
    lat_cnt_d   = lat_cnt_q;
    tx_start_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    op_dec      = decode_op(bus.rx_data);

    case (state_q)
      IDLE: begin
        if (bus.rx_done) begin
          alu_a_d = bus.rx_data;
          state_d = GET_OP;
        end
      end
      GET_OP: begin
        if (bus.rx_done) begin
          if (op_dec[6]) begin
            alu_op_d = op_dec[5:0];
            state_d  = GET_B;
          end else begin
            tx_data_d   = ERR_BYTE;
            frame_err_d = 1'b1;
            state_d     = SEND;
          end
        end
      end
      GET_B: begin
        if (bus.rx_done) begin
          alu_b_d   = bus.rx_data;
          lat_cnt_d = '0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        overrun_d = bus.rx_done;
        if (lat_cnt_q == LW'(ALU_LAT - 1)) begin
          tx_data_d  = bus.alu_result;
          tx_start_d = 1'b1;
          state_d    = SEND;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      // The error path enters SEND without a strobe so tx_start lags frame_err by a cycle.
      SEND: begin
        overrun_d = bus.rx_done;
        if (tx_start_q) begin
          state_d = WAIT_TX;
        end else begin
          tx_start_d = 1'b1;
        end
      end
      WAIT_TX: begin
        overrun_d = bus.rx_done;
        if (bus.tx_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ALU_SEQ_TIMEOUT_EN
    to_cnt_d = '0;
    if ((state_q == GET_OP || state_q == GET_B) && !bus.rx_done) begin
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: vector table of full frames plus hand-written corner sequences.
// Covers both ALU_SEQ_TIMEOUT_EN builds; a second instance uses ALU_LAT=4.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic reset4;

  int checks   = 0;
  int failures = 0;
  int starts1  = 0;
  int ferr1    = 0;
  int ovr1     = 0;
  int starts4  = 0;
  int s0, f0, o0;

  alu_cmd_sequencer_if bus1 ();
  alu_cmd_sequencer_if bus4 ();

  alu_cmd_sequencer #(.ALU_LAT(1), .TIMEOUT_CYC(100), .ERR_BYTE(8'h3F)) dut (
    .clk(clk), .reset(reset), .bus(bus1.master)
  );

  alu_cmd_sequencer #(.ALU_LAT(4), .TIMEOUT_CYC(100), .ERR_BYTE(8'h3F)) dut4 (
    .clk(clk), .reset(reset4), .bus(bus4.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] op_char;
    logic [7:0] b;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs [8];

  // Behavioural ALU standing in for the real one; shifts use the low three bits of B.
  function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return a >> b[2:0];
      6'b000010: return a << b[2:0];
      default:   return 8'h00;
    endcase
  endfunction

  always_comb bus1.alu_result = aluModel(bus1.alu_a, bus1.alu_b, bus1.alu_op);
  always_comb bus4.alu_result = aluModel(bus4.alu_a, bus4.alu_b, bus4.alu_op);

  always @(negedge clk) begin
    if (bus1.tx_start)  starts1++;
    if (bus1.frame_err) ferr1++;
    if (bus1.overrun)   ovr1++;
    if (bus4.tx_start)  starts4++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus1.rx_data = b;
    bus1.rx_done = 1'b1;
    tick();
    bus1.rx_done = 1'b0;
  endtask

  task automatic pulseTxDone();
    bus1.tx_done = 1'b1;
    tick();
    bus1.tx_done = 1'b0;
  endtask

  task automatic sendByte4(input logic [7:0] b);
    bus4.rx_data = b;
    bus4.rx_done = 1'b1;
    tick();
    bus4.rx_done = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    reset4 = 1'b1;
    bus1.rx_data = 8'h00; bus1.rx_done = 1'b0; bus1.tx_done = 1'b0;
    bus4.rx_data = 8'h00; bus4.rx_done = 1'b0; bus4.tx_done = 1'b0;

    vecs[0] = '{8'h05, 8'h2B, 8'h03, 6'b100000, 8'h08};
    vecs[1] = '{8'h10, 8'h2D, 8'h03, 6'b100010, 8'h0D};
    vecs[2] = '{8'hF0, 8'h26, 8'h3C, 6'b100100, 8'h30};
    vecs[3] = '{8'h0F, 8'h7C, 8'h30, 6'b100101, 8'h3F};
    vecs[4] = '{8'hFF, 8'h5E, 8'h0F, 6'b100110, 8'hF0};
    vecs[5] = '{8'h01, 8'h7E, 8'h02, 6'b100111, 8'hFC};
    vecs[6] = '{8'h80, 8'h3E, 8'h03, 6'b000011, 8'h10};
    vecs[7] = '{8'h01, 8'h3C, 8'h04, 6'b000010, 8'h10};

    repeat (3) tick();
    checkOutput("reset_outputs", {bus1.alu_a, bus1.alu_b, bus1.alu_op, bus1.tx_data,
                bus1.tx_start, bus1.busy, bus1.frame_err, bus1.overrun}, 64'h0);
    checkOutput("reset_outputs4", {bus4.alu_a, bus4.alu_b, bus4.alu_op, bus4.tx_data,
                bus4.tx_start, bus4.busy, bus4.frame_err, bus4.overrun}, 64'h0);
    reset  = 1'b0;
    reset4 = 1'b0;
    tick();

    // Full frames: operands, opcode, result latency and single tx_start per frame
    for (int i = 0; i < 8; i++) begin
      s0 = starts1;
      applyStimulus(vecs[i].a);
      checkOutput("alu_a", bus1.alu_a, vecs[i].a);
      checkOutput("busy_get_op", bus1.busy, 1);
      applyStimulus(vecs[i].op_char);
      checkOutput("alu_op", bus1.alu_op, vecs[i].exp_op);
      applyStimulus(vecs[i].b);
      checkOutput("alu_b", bus1.alu_b, vecs[i].b);
      checkOutput("tx_start_early", bus1.tx_start, 0);
      tick();
      checkOutput("tx_start", bus1.tx_start, 1);
      checkOutput("tx_data", bus1.tx_data, vecs[i].exp_res);
      tick();
      checkOutput("tx_start_len", bus1.tx_start, 0);
      checkOutput("busy_wait_tx", bus1.busy, 1);
      checkOutput("tx_data_hold", bus1.tx_data, vecs[i].exp_res);
      tick();
      pulseTxDone();
      checkOutput("busy_idle", bus1.busy, 0);
      checkOutput("start_count", starts1 - s0, 1);
    end

    // Invalid operator: error byte sent, opcode untouched, then a fresh frame
    s0 = starts1;
    f0 = ferr1;
    applyStimulus(8'h07);
    applyStimulus(8'h2A);
    checkOutput("inv_frame_err", bus1.frame_err, 1);
    checkOutput("inv_tx_start_early", bus1.tx_start, 0);
    checkOutput("inv_alu_op_kept", bus1.alu_op, 6'b000010);
    tick();
    checkOutput("inv_tx_start", bus1.tx_start, 1);
    checkOutput("inv_tx_data", bus1.tx_data, 8'h3F);
    checkOutput("inv_frame_err_len", bus1.frame_err, 0);
    tick();
    checkOutput("inv_tx_start_len", bus1.tx_start, 0);
    checkOutput("inv_busy", bus1.busy, 1);
    pulseTxDone();
    checkOutput("inv_busy_idle", bus1.busy, 0);
    checkOutput("inv_err_count", ferr1 - f0, 1);
    checkOutput("inv_start_count", starts1 - s0, 1);
    applyStimulus(8'h01);
    checkOutput("fresh_alu_a", bus1.alu_a, 8'h01);
    applyStimulus(8'h2D);
    checkOutput("fresh_alu_op", bus1.alu_op, 6'b100010);
    applyStimulus(8'h01);
    tick();
    checkOutput("fresh_tx_data", bus1.tx_data, 8'h00);
    tick();
    pulseTxDone();

    // Overrun in WAIT_TX, and a byte coinciding with tx_done
    o0 = ovr1;
    applyStimulus(8'h20);
    applyStimulus(8'h2B);
    applyStimulus(8'h01);
    tick();
    tick();
    applyStimulus(8'h55);
    checkOutput("ovr_pulse", bus1.overrun, 1);
    checkOutput("ovr_alu_a_kept", bus1.alu_a, 8'h20);
    tick();
    checkOutput("ovr_pulse_len", bus1.overrun, 0);
    bus1.rx_data = 8'h77;
    bus1.rx_done = 1'b1;
    bus1.tx_done = 1'b1;
    tick();
    bus1.rx_done = 1'b0;
    bus1.tx_done = 1'b0;
    checkOutput("ovr_same_cycle", bus1.overrun, 1);
    checkOutput("ovr_same_busy", bus1.busy, 0);
    checkOutput("ovr_same_alu_a", bus1.alu_a, 8'h20);
    applyStimulus(8'h09);
    checkOutput("ovr_next_alu_a", bus1.alu_a, 8'h09);
    applyStimulus(8'h2B);
    applyStimulus(8'h01);
    tick();
    checkOutput("ovr_tx_data", bus1.tx_data, 8'h0A);
    tick();
    pulseTxDone();
    checkOutput("ovr_count", ovr1 - o0, 2);

    // Inter-byte timeout behaviour after operand A
    f0 = ferr1;
    s0 = starts1;
    applyStimulus(8'h04);
`ifdef ALU_SEQ_TIMEOUT_EN
    repeat (99) tick();
    checkOutput("to_busy_before", bus1.busy, 1);
    checkOutput("to_err_before", bus1.frame_err, 0);
    tick();
    checkOutput("to_frame_err", bus1.frame_err, 1);
    checkOutput("to_idle", bus1.busy, 0);
    repeat (5) tick();
    checkOutput("to_no_start", starts1 - s0, 0);
    checkOutput("to_err_count", ferr1 - f0, 1);
`else
    repeat (150) tick();
    checkOutput("to_still_busy", bus1.busy, 1);
    checkOutput("to_no_err", ferr1 - f0, 0);
    applyStimulus(8'h2B);
    applyStimulus(8'h02);
    tick();
    checkOutput("to_late_tx_data", bus1.tx_data, 8'h06);
    tick();
    pulseTxDone();
    checkOutput("to_late_start", starts1 - s0, 1);
`endif

    // Back-to-back frames, second A one cycle after tx_done
    o0 = ovr1;
    s0 = starts1;
    applyStimulus(8'h22);
    applyStimulus(8'h2B);
    applyStimulus(8'h11);
    tick();
    checkOutput("b2b_tx_data1", bus1.tx_data, 8'h33);
    tick();
    pulseTxDone();
    applyStimulus(8'h40);
    checkOutput("b2b_alu_a2", bus1.alu_a, 8'h40);
    checkOutput("b2b_busy2", bus1.busy, 1);
    applyStimulus(8'h2D);
    applyStimulus(8'h10);
    tick();
    checkOutput("b2b_tx_data2", bus1.tx_data, 8'h30);
    tick();
    pulseTxDone();
    checkOutput("b2b_starts", starts1 - s0, 2);
    checkOutput("b2b_no_overrun", ovr1 - o0, 0);

    // ALU_LAT=4: reset two cycles after B aborts, then latency of a full frame
    sendByte4(8'h03);
    sendByte4(8'h2B);
    sendByte4(8'h04);
    tick();
    reset4 = 1'b1;
    tick();
    checkOutput("rst_exec_outputs", {bus4.alu_a, bus4.alu_b, bus4.alu_op, bus4.tx_data,
                bus4.tx_start, bus4.busy, bus4.frame_err, bus4.overrun}, 64'h0);
    reset4 = 1'b0;
    s0 = starts4;
    repeat (8) tick();
    checkOutput("rst_no_start", starts4 - s0, 0);
    sendByte4(8'h11);
    checkOutput("rst_next_alu_a", bus4.alu_a, 8'h11);
    checkOutput("rst_next_busy", bus4.busy, 1);
    sendByte4(8'h2B);
    sendByte4(8'h05);
    repeat (3) tick();
    checkOutput("lat4_start_early", bus4.tx_start, 0);
    tick();
    checkOutput("lat4_start", bus4.tx_start, 1);
    checkOutput("lat4_tx_data", bus4.tx_data, 8'h16);
    tick();
    bus4.tx_done = 1'b1;
    tick();
    bus4.tx_done = 1'b0;
    checkOutput("lat4_idle", bus4.busy, 0);
    checkOutput("lat4_start_count", starts4 - s0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
